// File: rtl/alu_pkg.sv
// Shared constants, FSM encoding and opcode helpers
// for the bit-serial ALU controller.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLT_FIX,
    S_DONE
  } state_t;

  function automatic logic uses_binv(
    input logic [3:0] op
  );
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  function automatic logic is_arith(
    input logic [3:0] op
  );
    return (op == ALU_ADD) || uses_binv(op);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/result bundle between a requester
// and the bit-serial ALU controller.
interface serial_alu_ctrl_if;
  import alu_pkg::*;

  logic              start;
  logic [3:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, overflow
  );

endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: logic ops plus a full adder
// with optional B inversion for SUB/SLT.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binv,
  input  logic [3:0] op,
  output logic       r,
  output logic       cout
);

  logic bb;
  logic sum;

  assign bb   = b ^ binv;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (cin & (a ^ bb));

  always_comb begin
    r = 1'b0;
    unique case (1'b1)
      op == ALU_AND: r = a & b;
      op == ALU_OR:  r = a | b;
      op == ALU_NOR: r = ~(a | b);
      is_arith(op):  r = sum;
      default:       r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial 32-bit ALU sequencer, LSB first.
// SERIAL_ALU_OVF_EN enables overflow and signed-correct SLT.
module serial_alu_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  serial_alu_ctrl_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic              ovf_q;
  logic              done_q;
  logic              zero_q;
  logic              ovf_out_q;

  logic accept;
  logic last_bit;
  logic r_bit;
  logic c_out;
  logic ovf_bit;
  logic slt_set;

  assign accept   = (state == S_IDLE) && bus.start;
  assign last_bit = idx_q == IDX_W'(DATA_W - 1);

  alu_bit_slice u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .binv (uses_binv(op_q)),
    .op   (op_q),
    .r    (r_bit),
    .cout (c_out)
  );

`ifdef SERIAL_ALU_OVF_EN
  assign ovf_bit = is_arith(op_q)
                 & (carry_q ^ c_out);
`else
  assign ovf_bit = 1'b0;
`endif

  // ovf_q is 0 when overflow is disabled,
  // so this degrades to the raw sign bit
  assign slt_set = res_q[DATA_W-1] ^ ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.start) state_nxt = S_RUN;
      S_RUN:
        if (last_bit)
          state_nxt = (op_q == ALU_SLT)
                    ? S_SLT_FIX : S_DONE;
      S_SLT_FIX: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q    <= bus.op;
        a_q     <= bus.a;
        b_q     <= bus.b;
        res_q   <= '0;
        idx_q   <= '0;
        carry_q <= uses_binv(bus.op);
        ovf_q   <= 1'b0;
      end
      if (state == S_RUN) begin
        res_q[idx_q] <= r_bit;
        carry_q      <= c_out;
        idx_q        <= idx_q + IDX_W'(1);
        if (last_bit) ovf_q <= ovf_bit;
      end
      if (state == S_SLT_FIX)
        res_q <= {{(DATA_W-1){1'b0}}, slt_set};
      if (state == S_DONE) begin
        done_q    <= 1'b1;
        zero_q    <= (res_q == '0);
        ovf_out_q <= ovf_q;
      end
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_out_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: a reference
// model pushes expectations, a done monitor pops them.
module tb_serial_alu_ctrl;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   dn_cnt = 0;
  int   last_acc = 0;
  exp_t sbq[$];

  serial_alu_ctrl_if bus();

  serial_alu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    logic [31:0] s;
    logic [31:0] d;
    logic so;
    logic dov;
    s   = a + b;
    d   = a - b;
    so  = (a[31] == b[31]) && (s[31] != a[31]);
    dov = (a[31] != b[31]) && (d[31] != a[31]);
    e.ovf = 1'b0;
    e.acc = 0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  begin e.res = s; e.ovf = so;  end
      4'd6:  begin e.res = d; e.ovf = dov; end
      4'd7:  begin
`ifdef SERIAL_ALU_OVF_EN
        e.res = {31'b0,
                 ($signed(a) < $signed(b))};
`else
        e.res = {31'b0, d[31]};
`endif
        e.ovf = dov;
      end
      4'd12: e.res = ~(a | b);
      default: e.res = 32'h0;
    endcase
`ifndef SERIAL_ALU_OVF_EN
    e.ovf = 1'b0;
`endif
    e.zero = (e.res == 32'h0);
    e.lat  = (op == 4'd7) ? 34 : 33;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      dn_cnt++;
      if (sbq.size() == 0) begin
        chk("unexp_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("zero", 64'(bus.zero), 64'(e.zero));
        chk("ovf", 64'(bus.overflow), 64'(e.ovf));
        chk("latency", 64'(cyc - e.acc),
            64'(e.lat));
      end
    end
  end

  task automatic issue(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          push
  );
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("issue_to", 64'd1, 64'd0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    e = model(op, a, b);
    e.acc = cyc;
    last_acc = cyc;
    if (push) sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_to", 64'd1, 64'd0);
  endtask

  logic [3:0] ops [7] = '{
    4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd9
  };

  initial begin
    int p;
    int d0;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_res", 64'(bus.result), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    rst_n = 1'b1;

    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    drain();
    issue(ALU_SUB, 32'd5, 32'd7, 1'b1);
    drain();
    issue(ALU_SLT, 32'h7FFF_FFFF,
          32'hFFFF_FFFF, 1'b1);
    drain();

    issue(ALU_NOR, 32'h1234_5678,
          32'h0F0F_0000, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = ALU_ADD;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    issue(ALU_ADD, 32'h1111_1111,
          32'h2222_2222, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_done", 64'(bus.done), 64'd0);
    chk("mid_res", 64'(bus.result), 64'd0);
    chk("mid_zero", 64'(bus.zero), 64'd0);
    chk("mid_ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dn_cnt;
    repeat (40) @(negedge clk);
    chk("mid_nodone", 64'(dn_cnt - d0), 64'd0);

    issue(4'd9, 32'hA5A5_A5A5,
          32'hA5A5_A5A5, 1'b1);
    drain();

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    p = last_acc;
    issue(ALU_AND, 32'hF0F0_1234,
          32'hFF00_FF00, 1'b1);
    chk("b2b_period", 64'(last_acc - p), 64'd34);
    p = last_acc;
    issue(ALU_OR, 32'h0000_00F0,
          32'h0F00_000F, 1'b1);
    chk("b2b_period2", 64'(last_acc - p), 64'd34);
    drain();

    for (int i = 0; i < 10; i++) begin
      issue(ops[$urandom_range(0, 6)],
            $urandom, $urandom, 1'b1);
    end
    issue(ALU_SLT, 32'h8000_0000, 32'h1, 1'b1);
    issue(ALU_SUB, 32'h8000_0000, 32'h1, 1'b1);
    drain();
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
